cpu_debug_ocimem: RTL and testbench
===================================

Name: cpu_debug_ocimem

Overview:
- Consumes the decoded JTAG debug strobes and the 38-bit `jdo` word from the debug-slave sysclk stage.
- Executes them against a small on-chip debug monitor RAM and a monitor control/status register.
- Produces `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into the debug-slave TCK capture path.
- Also exposes an Avalon-MM style CPU slave port to the same RAM and control register. The JTAG side has priority on the single RAM port.

Parameters:
- ADDR_W, 8, debug RAM word-address width; depth = 2**ADDR_W words of 32 bits (ADDR_W ≤ 9).
- RESET_MONDREG, 32'h0, reset value of `MonDReg`.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  JTAG data word, stable whenever a take_* strobe is high
- take_action_ocimem_a  in  1  one-cycle strobe: address/control command
- take_no_action_ocimem_a  in  1  one-cycle strobe: read-next command
- take_action_ocimem_b  in  1  one-cycle strobe: write-next command
- cpu_address  in  ADDR_W+1  bit ADDR_W=1 selects the control register, else a RAM word
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request
- cpu_writedata  in  32  CPU write data
- cpu_readdata  out  32  CPU read data, valid when request high and cpu_waitrequest low
- cpu_waitrequest  out  1  CPU stall
- MonDReg  out  32  JTAG read-back data register
- monitor_ready  out  1  sticky ready flag
- monitor_error  out  1  sticky error flag
- monitor_go  out  1  sticky go request to the CPU debug monitor

Behaviour:
- Reset: async on reset_n low.
  - MonAReg=0, MonDReg=RESET_MONDREG.
  - monitor_ready, monitor_error, monitor_go all 0.
  - cpu_waitrequest=1, cpu_readdata=0, FSM=IDLE.
  - RAM contents are not reset.
- JTAG commands (strobes are mutually exclusive; at most one per cycle):
  - take_action_ocimem_a:
    - if jdo[17], MonAReg <= jdo[26+ADDR_W-1:26];
    - if jdo[22], monitor_go <= 1;
    - if jdo[23], monitor_ready <= 0;
    - if jdo[24], monitor_error <= 0;
    - if jdo[25], read RAM at the new (or current) MonAReg, then MonAReg += 1.
  - take_no_action_ocimem_a: read RAM at MonAReg, then MonAReg += 1.
  - take_action_ocimem_b: write jdo[34:3] to RAM[MonAReg], then MonAReg += 1.
  - MonAReg wraps from 2**ADDR_W-1 to 0 silently.
- RAM: single port, synchronous read, 1-cycle latency. MonDReg loads RAM data exactly 1 clk after the JTAG read strobe.
- Arbitration: a JTAG command always uses the port in its strobe cycle. Any CPU RAM access presented in that cycle is not accepted: it keeps cpu_waitrequest=1 and retries.
- CPU FSM:
  - IDLE: on a cpu_read or cpu_write to RAM with no JTAG strobe, the access is issued. A write completes and goes to ACK; a read goes to RD_WAIT.
  - RD_WAIT: capture RAM data into cpu_readdata; go to ACK.
  - ACK: cpu_waitrequest=0 for exactly 1 cycle; return to IDLE.
  - Control-register accesses do not use the RAM and go IDLE → ACK directly.
  - Latency: RAM write 2 cycles, RAM read 3 cycles, control-register access 2 cycles (request to waitrequest low, inclusive).
  - cpu_waitrequest=1 in IDLE and RD_WAIT.
- Control register (cpu_address[ADDR_W]=1):
  - Read returns {29'b0, monitor_go, monitor_error, monitor_ready}.
  - Write: bit0=1 sets monitor_ready; bit1=1 sets monitor_error; bit2=1 clears monitor_go.
  - The register effect occurs in the cycle the request is accepted in IDLE.
- Simultaneous set and clear of one flag: the JTAG action wins.
- cpu_read and cpu_write both high: treated as a read; monitor_error <= 1.
- A request dropped mid-FSM is completed internally and the ACK is ignored.
- Reset mid-operation aborts the FSM to IDLE. Any in-flight RAM write may or may not have landed.

Decomposition:
- Shared package, ocimem_pkg:
  - jdo bit-position constants (ADDR_LSB=26, LOAD_ADDR=17, SET_GO=22, CLR_READY=23, CLR_ERROR=24, READ_REQ=25, WDATA_LSB=3);
  - CPU FSM state enum {IDLE, RD_WAIT, ACK};
  - control-register bit indices.
- One sub-module, cpu_debug_ocimem_ram: inferred single-port synchronous RAM with 32-bit data and ADDR_W-bit address.

Test Plan:
- JTAG load-and-read:
  - Preload RAM[5]=32'hDEADBEEF.
  - ocimem_a with jdo[17]=1, addr field=5, jdo[25]=1.
  - Expect MonDReg=32'hDEADBEEF one clk later and MonAReg=6.
- JTAG write-next across wrap (ADDR_W=8):
  - Load MonAReg=255; ocimem_b with jdo[34:3]=32'h12345678; then ocimem_b with jdo[34:3]=32'hA5A5A5A5.
  - Expect RAM[255]=32'h12345678, RAM[0]=32'hA5A5A5A5, MonAReg=1.
- CPU/JTAG collision:
  - cpu_write RAM[3]=32'h1 in the same cycle as take_no_action_ocimem_a.
  - Expect the JTAG read to complete first and the CPU waitrequest to drop one cycle later than normal.
  - Expect RAM[3]=32'h1 afterwards.
- Flags:
  - CPU writes control=3'b011 → monitor_ready=1, monitor_error=1.
  - JTAG ocimem_a with jdo[23]=jdo[24]=1 → both 0.
  - JTAG jdo[22]=1 → monitor_go=1; CPU read control returns 32'h4.
- CPU read latency: cpu_read RAM[7] held high → cpu_waitrequest low in exactly the 3rd cycle with the correct cpu_readdata.
- Async reset mid-RD_WAIT: reset_n low between clock edges → all outputs take their reset values immediately; FSM is IDLE after release.

Source files
------------

// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared constants for the on-chip debug monitor memory block:
// jdo field positions, CPU-port FSM states and control-register bit indices.
package ocimem_pkg;

  localparam int ADDR_LSB  = 26;
  localparam int LOAD_ADDR = 17;
  localparam int SET_GO    = 22;
  localparam int CLR_READY = 23;
  localparam int CLR_ERROR = 24;
  localparam int READ_REQ  = 25;
  localparam int WDATA_LSB = 3;

  localparam int CTRL_READY = 0;
  localparam int CTRL_ERROR = 1;
  localparam int CTRL_GO    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } cpu_state_e;

endpackage

// File: rtl/cpu_debug_ocimem_ram.sv
// Single-port debug monitor RAM, 32-bit words, synchronous read with one cycle latency.
// Contents are deliberately not reset.
module cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_debug_ocimem.sv
// Executes JTAG debug-slave commands against the monitor RAM and flags, and serves
// an Avalon-MM style CPU port to the same RAM/control register (JTAG owns the port first).
//
// state   | meaning
// IDLE    | waiting for a CPU request; waitrequest high
// RD_WAIT | RAM read issued, data captured into cpu_readdata at the end of this cycle
// ACK     | waitrequest low for one cycle, then back to IDLE
module cpu_debug_ocimem
  import ocimem_pkg::*;
#(
  parameter int          ADDR_W        = 8,
  parameter logic [31:0] RESET_MONDREG = 32'h0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [37:0]     jdo,
  input  logic            take_action_ocimem_a,
  input  logic            take_no_action_ocimem_a,
  input  logic            take_action_ocimem_b,
  input  logic [ADDR_W:0] cpu_address,
  input  logic            cpu_read,
  input  logic            cpu_write,
  input  logic [31:0]     cpu_writedata,
  output logic [31:0]     cpu_readdata,
  output logic            cpu_waitrequest,
  output logic [31:0]     MonDReg,
  output logic            monitor_ready,
  output logic            monitor_error,
  output logic            monitor_go
);

  cpu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] mon_a_reg, jtag_addr, ram_addr;
  logic              jtag_strobe, jtag_load, jtag_rd, jtag_wr, jtag_rd_q;
  logic              cpu_req, cpu_is_ctrl, cpu_ram_go, cpu_ctrl_go, cpu_rw_clash, ctrl_wr;
  logic              ready_nxt, error_nxt, go_nxt;
  logic              ram_we;
  logic [31:0]       ram_wdata, ram_q, ctrl_status;
  logic              unused_bits;

  assign unused_bits = ^{jdo[37:35], jdo[2:0], cpu_writedata[31:3]};

  assign jtag_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign jtag_load   = take_action_ocimem_a & jdo[LOAD_ADDR];
  assign jtag_rd     = (take_action_ocimem_a & jdo[READ_REQ]) | take_no_action_ocimem_a;
  assign jtag_wr     = take_action_ocimem_b;
  // A load-and-read command reads from the freshly loaded address, not the old one.
  assign jtag_addr   = jtag_load ? jdo[ADDR_LSB +: ADDR_W] : mon_a_reg;

  assign cpu_req      = cpu_read | cpu_write;
  assign cpu_is_ctrl  = cpu_address[ADDR_W];
  assign cpu_ram_go   = (state == IDLE) & cpu_req & ~cpu_is_ctrl & ~jtag_strobe;
  assign cpu_ctrl_go  = (state == IDLE) & cpu_req & cpu_is_ctrl;
  assign cpu_rw_clash = (cpu_ram_go | cpu_ctrl_go) & cpu_read & cpu_write;
  assign ctrl_wr      = cpu_ctrl_go & cpu_write & ~cpu_read;

  assign ram_we    = jtag_strobe ? jtag_wr : (cpu_ram_go & ~cpu_read);
  assign ram_addr  = jtag_strobe ? jtag_addr : cpu_address[ADDR_W-1:0];
  assign ram_wdata = jtag_strobe ? jdo[WDATA_LSB +: 32] : cpu_writedata;

  assign ctrl_status     = {29'b0, monitor_go, monitor_error, monitor_ready};
  assign cpu_waitrequest = (state != ACK);

  cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_ctrl_go || (cpu_ram_go && !cpu_read)) state_nxt = ACK;
        else if (cpu_ram_go)                          state_nxt = RD_WAIT;
      end
      RD_WAIT: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // JTAG actions are applied last so they win over a same-cycle CPU set/clear.
  always_comb begin
    ready_nxt = monitor_ready;
    error_nxt = monitor_error;
    go_nxt    = monitor_go;
    if (ctrl_wr && cpu_writedata[CTRL_READY]) ready_nxt = 1'b1;
    if ((ctrl_wr && cpu_writedata[CTRL_ERROR]) || cpu_rw_clash) error_nxt = 1'b1;
    if (ctrl_wr && cpu_writedata[CTRL_GO]) go_nxt = 1'b0;
    if (take_action_ocimem_a && jdo[CLR_READY]) ready_nxt = 1'b0;
    if (take_action_ocimem_a && jdo[CLR_ERROR]) error_nxt = 1'b0;
    if (take_action_ocimem_a && jdo[SET_GO])    go_nxt    = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      jtag_rd_q     <= 1'b0;
      MonDReg       <= RESET_MONDREG;
      cpu_readdata  <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
    end else begin
      state         <= state_nxt;
      monitor_ready <= ready_nxt;
      monitor_error <= error_nxt;
      monitor_go    <= go_nxt;
      jtag_rd_q     <= jtag_rd;
      if (jtag_strobe)
        mon_a_reg <= (jtag_rd || jtag_wr) ? jtag_addr + ADDR_W'(1) : jtag_addr;
      if (jtag_rd_q) MonDReg <= ram_q;
      if (cpu_ctrl_go && cpu_read) cpu_readdata <= ctrl_status;
      else if (state == RD_WAIT)   cpu_readdata <= ram_q;
    end
  end

endmodule

// File: tb/tb_cpu_debug_ocimem.sv
// Self-checking bench for cpu_debug_ocimem: directed scenarios plus a randomized
// JTAG/CPU mix checked against an array-based memory/pointer/flag model.
module tb_cpu_debug_ocimem;
  import ocimem_pkg::*;

  localparam int          AW        = 8;
  localparam logic [31:0] RST_MDR   = 32'h0BAD_F00D;
  localparam logic [AW:0] CTRL_ADDR = 9'h100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [AW:0] cpu_address = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go;

  cpu_debug_ocimem #(.ADDR_W(AW), .RESET_MONDREG(RST_MDR)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error), .monitor_go(monitor_go)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [0:255];
  logic [7:0]  ref_addr = '0;

  function automatic logic [37:0] mk_a(input bit ld, input logic [7:0] addr, input bit go,
                                       input bit cr, input bit ce, input bit rd);
    logic [37:0] j;
    j = '0;
    j[17] = ld; j[33:26] = addr; j[22] = go; j[23] = cr; j[24] = ce; j[25] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // kind: 0 = ocimem_a, 1 = no_action_a, 2 = ocimem_b; returns #1 after the strobe edge
  task automatic jtag_cmd(input int kind, input logic [37:0] w);
    jdo = w;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
  endtask

  // cyc = cycle (1-based, request cycle inclusive) in which waitrequest was low
  task automatic cpu_xfer(input logic [AW:0] addr, input bit rd, input bit wr,
                          input logic [31:0] wd, output logic [31:0] rdata, output int cyc);
    cpu_address = addr; cpu_read = rd; cpu_write = wr; cpu_writedata = wd;
    cyc = 1;
    while (cpu_waitrequest !== 1'b0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    rdata = cpu_readdata;
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (MonDReg !== RST_MDR) begin n_err++; $display("FAIL reset_mondreg got=%h exp=%h", MonDReg, RST_MDR); end
    n_cmp++; if ({monitor_go, monitor_error, monitor_ready} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {monitor_go, monitor_error, monitor_ready}); end
    n_cmp++; if (cpu_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_waitreq got=%b exp=1", cpu_waitrequest); end
    n_cmp++; if (cpu_readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata got=%h exp=0", cpu_readdata); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (dut.mon_a_reg !== 8'd0) begin n_err++; $display("FAIL reset_monareg got=%0d exp=0", dut.mon_a_reg); end
  endtask

  task automatic test_jtag_load_read();
    logic [31:0] rd; int cyc;
    cpu_xfer(9'd5, 0, 1, 32'hDEADBEEF, rd, cyc); ref_mem[5] = 32'hDEADBEEF;
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL cpu_write_latency got=%0d exp=2", cyc); end
    jtag_cmd(0, mk_a(1, 8'd5, 0, 0, 0, 1)); ref_addr = 8'd6;
    n_cmp++; if (MonDReg !== RST_MDR) begin n_err++; $display("FAIL mondreg_early got=%h exp=%h", MonDReg, RST_MDR); end
    @(posedge clk); #1;
    n_cmp++; if (MonDReg !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_read_data got=%h exp=deadbeef", MonDReg); end
    n_cmp++; if (dut.mon_a_reg !== ref_addr) begin n_err++; $display("FAIL load_read_addr got=%0d exp=%0d", dut.mon_a_reg, ref_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int cyc;
    jtag_cmd(0, mk_a(1, 8'd255, 0, 0, 0, 0));
    jtag_cmd(2, mk_b(32'h12345678));
    jtag_cmd(2, mk_b(32'hA5A5A5A5));
    ref_mem[255] = 32'h12345678; ref_mem[0] = 32'hA5A5A5A5; ref_addr = 8'd1;
    n_cmp++; if (dut.mon_a_reg !== 8'd1) begin n_err++; $display("FAIL wrap_addr got=%0d exp=1", dut.mon_a_reg); end
    jtag_cmd(0, mk_a(1, 8'd255, 0, 0, 0, 1)); @(posedge clk); #1;
    n_cmp++; if (MonDReg !== 32'h12345678) begin n_err++; $display("FAIL wrap_ram255 got=%h exp=12345678", MonDReg); end
    jtag_cmd(1, '0); @(posedge clk); #1; ref_addr = 8'd1;
    n_cmp++; if (MonDReg !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wrap_ram0 got=%h exp=a5a5a5a5", MonDReg); end
    cpu_xfer(9'd0, 1, 0, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'hA5A5A5A5 || cyc !== 3) begin n_err++; $display("FAIL wrap_cpu_read got=%h/%0d exp=a5a5a5a5/3", rd, cyc); end
  endtask

  task automatic test_collision();
    logic [31:0] rd; int cyc;
    cpu_xfer(9'd10, 0, 1, 32'hCAFE0010, rd, cyc); ref_mem[10] = 32'hCAFE0010;
    cpu_xfer(9'd3, 0, 1, 32'hFFFF0000, rd, cyc);
    jtag_cmd(0, mk_a(1, 8'd10, 0, 0, 0, 0));
    take_no_action_ocimem_a = 1'b1; jdo = '0;
    cpu_address = 9'd3; cpu_write = 1'b1; cpu_writedata = 32'h1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
    n_cmp++; if (cpu_waitrequest !== 1'b1) begin n_err++; $display("FAIL collide_wait_c2 got=%b exp=1", cpu_waitrequest); end
    @(posedge clk); #1;
    n_cmp++; if (cpu_waitrequest !== 1'b0) begin n_err++; $display("FAIL collide_wait_c3 got=%b exp=0", cpu_waitrequest); end
    n_cmp++; if (MonDReg !== 32'hCAFE0010) begin n_err++; $display("FAIL collide_jtag_data got=%h exp=cafe0010", MonDReg); end
    @(posedge clk); #1;
    cpu_write = 1'b0;
    ref_mem[3] = 32'h1; ref_addr = 8'd11;
    n_cmp++; if (dut.mon_a_reg !== ref_addr) begin n_err++; $display("FAIL collide_addr got=%0d exp=%0d", dut.mon_a_reg, ref_addr); end
    cpu_xfer(9'd3, 1, 0, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL collide_ram3 got=%h exp=1", rd); end
  endtask

  task automatic test_flags();
    logic [31:0] rd; int cyc;
    cpu_xfer(CTRL_ADDR, 0, 1, 32'h3, rd, cyc);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL ctrl_write_latency got=%0d exp=2", cyc); end
    n_cmp++; if ({monitor_go, monitor_error, monitor_ready} !== 3'b011) begin n_err++; $display("FAIL ctrl_set got=%b exp=011", {monitor_go, monitor_error, monitor_ready}); end
    jtag_cmd(0, mk_a(0, 8'd0, 0, 1, 1, 0));
    n_cmp++; if ({monitor_error, monitor_ready} !== 2'b00) begin n_err++; $display("FAIL jtag_clear got=%b exp=00", {monitor_error, monitor_ready}); end
    jtag_cmd(0, mk_a(0, 8'd0, 1, 0, 0, 0));
    n_cmp++; if (monitor_go !== 1'b1) begin n_err++; $display("FAIL jtag_go got=%b exp=1", monitor_go); end
    cpu_xfer(CTRL_ADDR, 1, 0, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'h4 || cyc !== 2) begin n_err++; $display("FAIL ctrl_read got=%h/%0d exp=4/2", rd, cyc); end
    // same-cycle CPU set error vs JTAG clear error
    jdo = mk_a(0, 8'd0, 0, 0, 1, 0); take_action_ocimem_a = 1'b1;
    cpu_address = CTRL_ADDR; cpu_write = 1'b1; cpu_writedata = 32'h2;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    n_cmp++; if (monitor_error !== 1'b0 || cpu_waitrequest !== 1'b0) begin n_err++; $display("FAIL jtag_wins got=%b/%b exp=0/0", monitor_error, cpu_waitrequest); end
    @(posedge clk); #1; cpu_write = 1'b0;
    cpu_xfer(CTRL_ADDR, 0, 1, 32'h4, rd, cyc);
    n_cmp++; if (monitor_go !== 1'b0) begin n_err++; $display("FAIL ctrl_clr_go got=%b exp=0", monitor_go); end
    cpu_xfer(CTRL_ADDR, 1, 1, 32'h1, rd, cyc);
    n_cmp++; if (rd !== 32'h0 || monitor_error !== 1'b1 || monitor_ready !== 1'b0) begin n_err++; $display("FAIL rw_clash got=%h err=%b rdy=%b exp=0/1/0", rd, monitor_error, monitor_ready); end
    jtag_cmd(0, mk_a(0, 8'd0, 0, 0, 1, 0));
  endtask

  task automatic test_cpu_read_latency();
    logic [31:0] rd, d; int cyc;
    d = $urandom;
    cpu_xfer(9'd7, 0, 1, d, rd, cyc); ref_mem[7] = d;
    cpu_xfer(9'd7, 1, 0, 32'h0, rd, cyc);
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL read_latency got=%0d exp=3", cyc); end
    n_cmp++; if (rd !== d) begin n_err++; $display("FAIL read_data got=%h exp=%h", rd, d); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp; logic [7:0] a; logic [63:0] junk; int cyc, op;
    jtag_cmd(0, mk_a(1, 8'd0, 0, 0, 0, 0)); ref_addr = 8'd0;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      jtag_cmd(2, mk_b(d));
      ref_mem[ref_addr] = d; ref_addr = ref_addr + 8'd1;
    end
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 5); a = 8'($urandom); d = $urandom;
      junk = {$urandom, $urandom};
      case (op)
        0: begin
          jtag_cmd(0, mk_a(1, a, 0, 0, 0, 1)); @(posedge clk); #1;
          exp = ref_mem[a]; ref_addr = a + 8'd1;
          n_cmp++; if (MonDReg !== exp) begin n_err++; $display("FAIL rnd_load_read @%0d got=%h exp=%h", a, MonDReg, exp); end
        end
        1: begin
          exp = ref_mem[ref_addr];
          jtag_cmd(1, junk[37:0]); @(posedge clk); #1;
          ref_addr = ref_addr + 8'd1;
          n_cmp++; if (MonDReg !== exp) begin n_err++; $display("FAIL rnd_read_next got=%h exp=%h", MonDReg, exp); end
        end
        2: begin
          jtag_cmd(2, {junk[37:35], d, junk[2:0]});
          ref_mem[ref_addr] = d; ref_addr = ref_addr + 8'd1;
        end
        3: begin
          cpu_xfer({1'b0, a}, 0, 1, d, rd, cyc); ref_mem[a] = d;
          n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL rnd_cpu_wr_lat got=%0d exp=2", cyc); end
        end
        4: begin
          cpu_xfer({1'b0, a}, 1, 0, 32'h0, rd, cyc);
          n_cmp++; if (rd !== ref_mem[a] || cyc !== 3) begin n_err++; $display("FAIL rnd_cpu_rd @%0d got=%h/%0d exp=%h/3", a, rd, cyc, ref_mem[a]); end
        end
        default: begin
          jtag_cmd(0, mk_a(1, a, 0, 0, 0, 0)); ref_addr = a;
        end
      endcase
      n_cmp++; if (dut.mon_a_reg !== ref_addr) begin n_err++; $display("FAIL rnd_addr got=%0d exp=%0d", dut.mon_a_reg, ref_addr); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; int cyc;
    cpu_xfer(CTRL_ADDR, 0, 1, 32'h3, rd, cyc);
    jtag_cmd(0, mk_a(1, 8'd7, 1, 0, 0, 1)); @(posedge clk); #1;
    cpu_address = 9'd7; cpu_read = 1'b1;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (MonDReg !== RST_MDR) begin n_err++; $display("FAIL areset_mondreg got=%h exp=%h", MonDReg, RST_MDR); end
    n_cmp++; if ({monitor_go, monitor_error, monitor_ready} !== 3'b000) begin n_err++; $display("FAIL areset_flags got=%b exp=000", {monitor_go, monitor_error, monitor_ready}); end
    n_cmp++; if (cpu_waitrequest !== 1'b1 || cpu_readdata !== 32'h0) begin n_err++; $display("FAIL areset_cpu got=%b/%h exp=1/0", cpu_waitrequest, cpu_readdata); end
    cpu_read = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    ref_addr = 8'd0;
    n_cmp++; if (dut.state !== IDLE || dut.mon_a_reg !== 8'd0) begin n_err++; $display("FAIL areset_idle got=%0d/%0d exp=0/0", dut.state, dut.mon_a_reg); end
    cpu_xfer(CTRL_ADDR, 1, 0, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'h0 || cyc !== 2) begin n_err++; $display("FAIL areset_ctrl got=%h/%0d exp=0/2", rd, cyc); end
  endtask

  initial begin
    test_reset();
    test_jtag_load_read();
    test_wrap();
    test_collision();
    test_flags();
    test_cpu_read_latency();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
